// File: rtl/twiddle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_seq
//  Description : Twiddle-factor sequencer for a radix-4 DIF FFT stage.
//                Walks butterfly index j (outer) and leg k (inner), forms the
//                exponent m = k * (j mod N/4^(s+1)) * 4^s, looks up a
//                quarter-wave cosine table and emits WR = cos, WI = -sin
//                (signed Q1.15) on a valid/ready stream.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start, stage       - start pulse and stage number s
//                busy               - sequence in progress
//                out_valid/ready    - output stream handshake
//                WR, WI, k, idx     - twiddle word, leg, butterfly index
//                last               - final beat of the stage
//  Revision    : 1.0 - initial release
// ============================================================================
module twiddle_seq #(
    parameter int LOG2N = 8,
    parameter int DW    = 16,
    parameter int SW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SW-1:0]    stage,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    WR,
    output logic [DW-1:0]    WI,
    output logic [1:0]       k,
    output logic [LOG2N-3:0] idx,
    output logic             last
);

    localparam int              c_n      = 1 << LOG2N;
    localparam int              c_nq     = c_n / 4;
    localparam int              c_aw     = LOG2N - 1;  // table address holds 0..N/4
    localparam logic [c_aw-1:0] c_nq_a   = c_aw'(c_nq);
    localparam logic [SW-1:0]   c_nstage = SW'(LOG2N / 2);
    localparam logic [LOG2N-1:0] c_last  = '1;
    localparam logic [LOG2N-1:0] c_one   = LOG2N'(1);
    localparam longint          c_amp    = (64'sd1 <<< (DW - 1)) - 64'sd1;

    // round(c_amp * cos(2*pi*r/N)) for 0 <= r <= N/4, evaluated at elaboration.
    // Integer Taylor series in 2^30 fixed point keeps it free of real math.
    function automatic logic [DW-1:0] f_cos(input int r);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (64'sd6746518852 * r) / c_n;   // 2*pi*2^30 * r / N
        x2   = (x * x) >>> 30;
        term = 64'sd1 <<< 30;
        acc  = term;
        for (int i = 1; i <= 12; i++) begin
            term = (term * x2) >>> 30;
            term = term / ((2 * i - 1) * (2 * i));
            if (i % 2 == 1) acc = acc - term;
            else            acc = acc + term;
        end
        acc = (acc * c_amp + (64'sd1 <<< 29)) >>> 30;
        if (acc < 0) acc = 0;
        return acc[DW-1:0];
    endfunction

    logic [DW-1:0] w_tab [0:c_nq];

    for (genvar gi = 0; gi <= c_nq; gi++) begin : g_tab
        localparam logic [DW-1:0] c_val = f_cos(gi);
        assign w_tab[gi] = c_val;
    end

    // ---------------- state ----------------
    logic                r_busy;
    logic [SW-1:0]       r_stage;
    // stage 1: beat counter (exponent is formed combinationally from it)
    logic                r_v1;
    logic [LOG2N-1:0]    r_cnt;
    // stage 2: table read
    logic                r_v2;
    logic [1:0]          r_k2;
    logic [LOG2N-3:0]    r_j2;
    logic                r_last2;
    logic [1:0]          r_q2;
    logic [DW-1:0]       r_cr;     // c(r)
    logic [DW-1:0]       r_cnr;    // c(N/4 - r)
    // stage 3: output register
    logic                r_ov;
    logic [DW-1:0]       r_wr;
    logic [DW-1:0]       r_wi;
    logic [1:0]          r_k3;
    logic [LOG2N-3:0]    r_j3;
    logic                r_last3;

    // ---------------- combinational ----------------
    logic                w_adv;
    logic                w_start_ok;
    logic [LOG2N-3:0]    w_j;
    logic [1:0]          w_kk;
    logic [LOG2N-3:0]    w_mask;
    logic [LOG2N-3:0]    w_p;
    logic [LOG2N-1:0]    w_kp;
    logic [LOG2N-1:0]    w_m;
    logic [1:0]          w_q;
    logic [LOG2N-3:0]    w_r;
    logic [c_aw-1:0]     w_addr_lo;
    logic [c_aw-1:0]     w_addr_hi;
    logic [DW-1:0]       w_wr;
    logic [DW-1:0]       w_wi;

    // Whole pipeline advances together; stalls only on a held output beat.
    assign w_adv      = !r_ov || out_ready;
    assign w_start_ok = start && !r_busy && (stage < c_nstage);

    assign w_j    = r_cnt[LOG2N-1:2];
    assign w_kk   = r_cnt[1:0];
    // j mod N/4^(s+1): the modulus is a power of two, so it is a mask.
    assign w_mask = {(LOG2N-2){1'b1}} >> {r_stage, 1'b0};
    assign w_p    = w_j & w_mask;
    assign w_kp   = {{(LOG2N-2){1'b0}}, w_kk} * {2'b00, w_p};
    assign w_m    = w_kp << {r_stage, 1'b0};

    assign w_q       = w_m[LOG2N-1:LOG2N-2];
    assign w_r       = w_m[LOG2N-3:0];
    assign w_addr_lo = {1'b0, w_r};
    assign w_addr_hi = c_nq_a - w_addr_lo;

    // Quadrant fold: WR = cos, WI = -sin.
    always_comb begin
        w_wr = r_cr;
        w_wi = -r_cnr;
        case (r_q2)
            2'd0: begin w_wr = r_cr;   w_wi = -r_cnr; end
            2'd1: begin w_wr = -r_cnr; w_wi = -r_cr;  end
            2'd2: begin w_wr = -r_cr;  w_wi = r_cnr;  end
            default: begin w_wr = r_cnr; w_wi = r_cr; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_stage <= '0;
            r_v1    <= 1'b0;
            r_cnt   <= '0;
            r_v2    <= 1'b0;
            r_k2    <= '0;
            r_j2    <= '0;
            r_last2 <= 1'b0;
            r_q2    <= '0;
            r_cr    <= '0;
            r_cnr   <= '0;
            r_ov    <= 1'b0;
            r_wr    <= '0;
            r_wi    <= '0;
            r_k3    <= '0;
            r_j3    <= '0;
            r_last3 <= 1'b0;
        end else begin
            if (w_adv) begin
                // stage 1 -> 2
                r_v2    <= r_v1;
                r_k2    <= w_kk;
                r_j2    <= w_j;
                r_last2 <= r_v1 && (r_cnt == c_last);
                r_q2    <= w_q;
                r_cr    <= w_tab[w_addr_lo];
                r_cnr   <= w_tab[w_addr_hi];
                // stage 2 -> 3
                r_ov    <= r_v2;
                r_wr    <= w_wr;
                r_wi    <= w_wi;
                r_k3    <= r_k2;
                r_j3    <= r_j2;
                r_last3 <= r_last2;
                // counter
                if (r_v1) begin
                    if (r_cnt == c_last) r_v1 <= 1'b0;
                    else                 r_cnt <= r_cnt + c_one;
                end
            end

            if (r_ov && out_ready && r_last3) r_busy <= 1'b0;

            // Accept only happens while idle, so the counter is not running.
            if (w_start_ok) begin
                r_busy  <= 1'b1;
                r_stage <= stage;
                r_v1    <= 1'b1;
                r_cnt   <= '0;
            end
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_ov;
    assign WR        = r_wr;
    assign WI        = r_wi;
    assign k         = r_k3;
    assign idx       = r_j3;
    assign last      = r_last3;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twiddle_seq
//  Description : Directed self-checking bench for twiddle_seq (N = 256).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_seq;

    localparam int LOG2N = 8;
    localparam int DW    = 16;
    localparam int SW    = 3;
    localparam int N     = 1 << LOG2N;

    logic             clk;
    logic             rst;
    logic             start;
    logic [SW-1:0]    stage;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    WR;
    logic [DW-1:0]    WI;
    logic [1:0]       k;
    logic [LOG2N-3:0] idx;
    logic             last;

    twiddle_seq #(.LOG2N(LOG2N), .DW(DW), .SW(SW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stage     (stage),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .WR        (WR),
        .WI        (WI),
        .k         (k),
        .idx       (idx),
        .last      (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_beat;

    logic [DW-1:0] cap_wr [N];
    logic [DW-1:0] cap_wi [N];
    logic [DW-1:0] ref_wr [N];
    logic [DW-1:0] ref_wi [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic vec(input string tag, input int b, input logic [DW-1:0] wr, input logic [DW-1:0] wi);
        chk({tag, "_wr"}, 32'(cap_wr[b]), 32'(wr));
        chk({tag, "_wi"}, 32'(cap_wi[b]), 32'(wi));
    endtask

    // Called on a negedge. Starts stage s, collects beats until N are
    // accepted (or the abort beat appears, where reset is applied).
    task automatic run_stage(input int s, input bit bp, input bit poke, input int abort_at);
        int               cyc;
        bit               hold;
        logic [DW-1:0]    h_wr;
        logic [DW-1:0]    h_wi;
        logic [1:0]       h_k;
        logic [LOG2N-3:0] h_idx;
        logic             h_last;
        hold  = 1'b0;
        h_wr  = '0;
        h_wi  = '0;
        h_k   = '0;
        h_idx = '0;
        h_last = 1'b0;
        start = 1'b1;
        stage = SW'(s);
        @(negedge clk);
        start = 1'b0;
        chk("busy_on", 32'(busy), 32'd1);
        cyc    = 1;
        n_beat = 0;
        while (n_beat < N && cyc < 8 * N) begin
            if (cyc < 3)  chk("valid_early", 32'(out_valid), 32'd0);
            if (cyc == 3) chk("valid_first", 32'(out_valid), 32'd1);
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_wr", 32'(WR), 32'(h_wr));
                chk("hold_wi", 32'(WI), 32'(h_wi));
                chk("hold_k", 32'(k), 32'(h_k));
                chk("hold_idx", 32'(idx), 32'(h_idx));
                chk("hold_last", 32'(last), 32'(h_last));
                hold = 1'b0;
            end
            if (abort_at >= 0 && out_valid && n_beat == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_wr", 32'(WR), 32'd0);
                chk("abort_wi", 32'(WI), 32'd0);
                rst = 1'b0;
                repeat (5) @(negedge clk);
                chk("abort_quiet", 32'(out_valid), 32'd0);
                return;
            end
            if (poke && cyc == 20) begin
                start = 1'b1;
                stage = 3'd2;
            end else begin
                start = 1'b0;
            end
            out_ready = bp ? ($urandom_range(1, 0) == 1) : 1'b1;
            if (out_valid) begin
                if (out_ready) begin
                    cap_wr[n_beat] = WR;
                    cap_wi[n_beat] = WI;
                    chk("beat_k", 32'(k), 32'(n_beat % 4));
                    chk("beat_idx", 32'(idx), 32'(n_beat / 4));
                    chk("beat_last", 32'(last), 32'(n_beat == N - 1));
                    n_beat++;
                end else begin
                    hold   = 1'b1;
                    h_wr   = WR;
                    h_wi   = WI;
                    h_k    = k;
                    h_idx  = idx;
                    h_last = last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("beat_count", 32'(n_beat), 32'(N));
        chk("busy_off", 32'(busy), 32'd0);
        chk("valid_off", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stage     = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_k", 32'(k), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_wr", 32'(WR), 32'd0);
        chk("rst_wi", 32'(WI), 32'd0);
        // start coincident with reset is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_start", 32'(busy), 32'd0);

        // Stage 0, with a start poked mid-run that must be ignored
        run_stage(0, 1'b0, 1'b1, -1);
        vec("s0_b0",   0,   16'h7FFF, 16'h0000);
        vec("s0_b5",   5,   16'h7FF5, 16'hFCDC);  // m=1: c(1)=32757, -c(63)=-804
        vec("s0_b129", 129, 16'h5A82, 16'hA57E);  // m=32
        vec("s0_b130", 130, 16'h0000, 16'h8001);  // m=64
        vec("s0_b131", 131, 16'hA57E, 16'hA57E);  // m=96
        vec("s0_b175", 175, 16'h800B, 16'h0324);  // m=129 (quadrant 2)

        // Out-of-range stage is ignored
        start = 1'b1;
        stage = 3'd4;
        @(negedge clk);
        start = 1'b0;
        chk("bad_stage_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("bad_stage_valid", 32'(out_valid), 32'd0);

        // Stage 1 reference run
        run_stage(1, 1'b0, 1'b0, -1);
        vec("s1_b33", 33, 16'h5A82, 16'hA57E);
        vec("s1_b34", 34, 16'h0000, 16'h8001);
        vec("s1_b35", 35, 16'hA57E, 16'hA57E);
        vec("s1_b65", 65, 16'h7FFF, 16'h0000);    // j=16 -> p=0
        vec("s1_b97", 97, 16'h5A82, 16'hA57E);    // j=24 -> p=8
        for (int b = 0; b < N; b++) begin
            ref_wr[b] = cap_wr[b];
            ref_wi[b] = cap_wi[b];
        end

        // Stage 1 with random backpressure, launched back-to-back
        run_stage(1, 1'b1, 1'b0, -1);
        for (int b = 0; b < N; b++) begin
            chk("bp_wr", 32'(cap_wr[b]), 32'(ref_wr[b]));
            chk("bp_wi", 32'(cap_wi[b]), 32'(ref_wi[b]));
        end

        // Stage 2
        run_stage(2, 1'b0, 1'b0, -1);
        vec("s2_b9",  9,  16'h5A82, 16'hA57E);    // j=2,k=1 -> m=32
        vec("s2_b26", 26, 16'h0000, 16'h8001);    // j=6,k=2 -> m=64
        vec("s2_b4",  4,  16'h7FFF, 16'h0000);    // j=1 -> p=0 mod 4? p=1,k=0

        // Stage 3: every twiddle is 1
        run_stage(3, 1'b0, 1'b0, -1);
        for (int b = 0; b < N; b++) vec("s3", b, 16'h7FFF, 16'h0000);

        // Reset at beat 100, then a clean restart
        run_stage(0, 1'b0, 1'b0, 100);
        run_stage(0, 1'b0, 1'b0, -1);
        vec("re_b0",   0,   16'h7FFF, 16'h0000);
        vec("re_b129", 129, 16'h5A82, 16'hA57E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
